// File: rtl/tdm_scan_ctrl_pkg.sv
// Shared types and default sizes for the TDM mux scan controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_scan_ctrl_pkg;

    localparam int N_CH_DEF    = 16;
    localparam int SEL_W_DEF   = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/tdm_scan_ctrl_if.sv
// Control, mux-drive and snapshot signals of the scan controller.
// Latency: n/a (wiring only).
// Backpressure: none; frame_valid is a one-cycle strobe with no ready.
interface tdm_scan_ctrl_if
    import tdm_scan_ctrl_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) ();

    logic               start;
    logic               stop;
    logic               cont;
    logic [N_CH-1:0]    ch_mask;
    logic [DWELL_W-1:0] dwell;
    logic               mux_y;
    logic [SEL_W-1:0]   sel;
    logic               mux_en;
    logic [N_CH-1:0]    sample;
    logic               frame_valid;
    logic               busy;

    // Controller side: drives the mux and publishes snapshots.
    modport master (
        input  start, stop, cont, ch_mask, dwell, mux_y,
        output sel, mux_en, sample, frame_valid, busy
    );

    // Environment side: issues commands, supplies mux output.
    modport slave (
        output start, stop, cont, ch_mask, dwell, mux_y,
        input  sel, mux_en, sample, frame_valid, busy
    );

endinterface

// File: rtl/tdm_next_ch.sv
// Finds the lowest set mask bit, either overall or strictly above cur_i.
// Latency: combinational.
// Backpressure: none.
module tdm_next_ch
    import tdm_scan_ctrl_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic [N_CH-1:0]  mask_i,
    input  logic [SEL_W-1:0] cur_i,
    input  logic             first_i,
    output logic [SEL_W-1:0] idx_o,
    output logic             found_o
);

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (first_i || (i > int'(cur_i)))) begin
                idx_o   = SEL_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tdm_scan_ctrl.sv
// Steps an N:1 mux through masked channels, samples each after its dwell, publishes a snapshot per frame.
// Latency: K*D dwell cycles plus one DONE cycle per frame, first dwell cycle right after start is taken.
// Backpressure: none; stop aborts on the next edge, start while busy is dropped.
module tdm_scan_ctrl
    import tdm_scan_ctrl_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_scan_ctrl_if.master bus
);

    state_t             state_q;
    logic [SEL_W-1:0]   sel_q;
    logic               mux_en_q;
    logic               fv_q;
    logic               busy_q;
    logic [N_CH-1:0]    sample_q;
    logic [N_CH-1:0]    shadow_q;
    logic [N_CH-1:0]    shadow_d;
    logic [N_CH-1:0]    mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_d;
    logic [DWELL_W-1:0] cnt_q;
    logic               last_cyc;
    logic               launch;
    logic [SEL_W-1:0]   first_idx;
    logic               first_found;
    logic [SEL_W-1:0]   next_idx;
    logic               next_found;

    // First channel comes from the live mask: it is only used at a latch point.
    tdm_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_first (
        .mask_i  (bus.ch_mask),
        .cur_i   ('0),
        .first_i (1'b1),
        .idx_o   (first_idx),
        .found_o (first_found)
    );

    // Next channel comes from the latched mask so mid-frame mask edits are ignored.
    tdm_next_ch #(.N_CH(N_CH), .SEL_W(SEL_W)) u_next (
        .mask_i  (mask_q),
        .cur_i   (sel_q),
        .first_i (1'b0),
        .idx_o   (next_idx),
        .found_o (next_found)
    );

    // Shadow with the current channel's bit merged, dwell clamp, end-of-dwell and launch decode.
    always_comb begin
        shadow_d         = shadow_q;
        shadow_d[sel_q]  = bus.mux_y;
        dwell_d          = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        last_cyc         = (cnt_q == (dwell_q - DWELL_W'(1)));
        launch           = ((state_q == ST_IDLE) ? bus.start : bus.cont) && first_found;
    end

    // Scan FSM with registered outputs; stop outranks every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            mux_en_q <= 1'b0;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            sample_q <= '0;
            shadow_q <= '0;
            mask_q   <= '0;
            dwell_q  <= '0;
            cnt_q    <= '0;
        end else if (bus.stop) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            mux_en_q <= 1'b0;
            fv_q     <= 1'b0;
            busy_q   <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            fv_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (launch) begin
                        state_q  <= ST_DWELL;
                        mask_q   <= bus.ch_mask;
                        dwell_q  <= dwell_d;
                        shadow_q <= '0;
                        sel_q    <= first_idx;
                        cnt_q    <= '0;
                        mux_en_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q  <= ST_IDLE;
                        sel_q    <= '0;
                        mux_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end
                end
                ST_DWELL: begin
                    if (last_cyc) begin
                        shadow_q <= shadow_d;
                        if (next_found) begin
                            sel_q <= next_idx;
                            cnt_q <= '0;
                        end else begin
                            state_q  <= ST_DONE;
                            mux_en_q <= 1'b0;
                            fv_q     <= 1'b1;
                            sample_q <= shadow_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + DWELL_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sel_q    <= '0;
                    mux_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel         = sel_q;
    assign bus.mux_en      = mux_en_q;
    assign bus.sample      = sample_q;
    assign bus.frame_valid = fv_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_tdm_scan_ctrl.sv
// Scoreboard bench for tdm_scan_ctrl: per-cycle expectations queued at start, compared each cycle.
// Latency: n/a.
// Backpressure: n/a.
module tb_tdm_scan_ctrl;

    typedef struct {
        logic [3:0]  sel;
        logic        en;
        logic        fv;
        logic        busy;
        logic [15:0] samp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] y_pat;
    logic [15:0] last_exp_sample;
    exp_t        exp_q[$];
    int          n_cmp;
    int          n_bad;

    tdm_scan_ctrl_if #(.N_CH(16), .SEL_W(4), .DWELL_W(8)) bus ();

    tdm_scan_ctrl #(.N_CH(16), .SEL_W(4), .DWELL_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Combinational mux model: output bit chosen by the select held this cycle.
    assign bus.mux_y = y_pat[bus.sel];

    // Queue the expected cycle-by-cycle behaviour of one frame.
    task automatic plan_frame(input logic [15:0] m, input logic [7:0] dw);
        int   d;
        exp_t e;
        d = (dw == 8'd0) ? 1 : int'(dw);
        for (int ch = 0; ch < 16; ch++) begin
            if (m[ch]) begin
                for (int k = 0; k < d; k++) begin
                    e.sel = 4'(ch); e.en = 1'b1; e.fv = 1'b0; e.busy = 1'b1; e.samp = '0;
                    exp_q.push_back(e);
                end
            end
        end
        e.sel = '0; e.en = 1'b0; e.fv = 1'b1; e.busy = 1'b1; e.samp = y_pat & m;
        exp_q.push_back(e);
    endtask

    // Pops one expectation per cycle, shortly after each active edge.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst_n) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if (bus.mux_en !== e.en) begin
                        n_bad++; $display("FAIL mon_mux_en: got %b want %b @%0t", bus.mux_en, e.en, $time);
                    end
                    n_cmp++;
                    if (bus.frame_valid !== e.fv) begin
                        n_bad++; $display("FAIL mon_frame_valid: got %b want %b @%0t", bus.frame_valid, e.fv, $time);
                    end
                    n_cmp++;
                    if (bus.busy !== e.busy) begin
                        n_bad++; $display("FAIL mon_busy: got %b want %b @%0t", bus.busy, e.busy, $time);
                    end
                    if (e.fv) begin
                        last_exp_sample = e.samp;
                        n_cmp++;
                        if (bus.sample !== e.samp) begin
                            n_bad++; $display("FAIL mon_sample: got %h want %h @%0t", bus.sample, e.samp, $time);
                        end
                    end else begin
                        n_cmp++;
                        if (bus.sel !== e.sel) begin
                            n_bad++; $display("FAIL mon_sel: got %0d want %0d @%0t", bus.sel, e.sel, $time);
                        end
                    end
                end else begin
                    n_cmp++;
                    if (bus.mux_en !== 1'b0 || bus.frame_valid !== 1'b0) begin
                        n_bad++;
                        $display("FAIL mon_idle: got mux_en=%b frame_valid=%b want 0/0 @%0t",
                                 bus.mux_en, bus.frame_valid, $time);
                    end
                end
            end
        end
    endtask

    // Wait for the scoreboard to empty within a cycle budget, then let the FSM settle in IDLE.
    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.sel !== 4'd0) begin n_bad++; $display("FAIL rst_sel: got %0d want 0", bus.sel); end
        n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL rst_mux_en: got %b want 0", bus.mux_en); end
        n_cmp++; if (bus.sample !== 16'h0) begin n_bad++; $display("FAIL rst_sample: got %h want 0", bus.sample); end
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fv: got %b want 0", bus.frame_valid); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        y_pat = 16'h0004;
        bus.ch_mask = 16'h0005; bus.dwell = 8'd2; bus.cont = 1'b0; bus.start = 1'b1;
        plan_frame(16'h0005, 8'd2);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(20);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_after: got %b want 0", bus.busy); end
        n_cmp++; if (bus.sample !== 16'h0004) begin n_bad++; $display("FAIL basic_sample_hold: got %h want 0004", bus.sample); end
    endtask

    task automatic test_dwell_zero_full();
        y_pat = 16'hFFFF;
        bus.ch_mask = 16'hFFFF; bus.dwell = 8'd0; bus.start = 1'b1;
        plan_frame(16'hFFFF, 8'd0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(40);
    endtask

    task automatic test_cont_mask_update();
        y_pat = 16'h8002;
        bus.ch_mask = 16'h0003; bus.dwell = 8'd1; bus.cont = 1'b1; bus.start = 1'b1;
        plan_frame(16'h0003, 8'd1);
        plan_frame(16'h8000, 8'd1);
        @(negedge clk);
        bus.start = 1'b0;
        bus.ch_mask = 16'h8000;
        repeat (3) @(negedge clk);
        bus.cont = 1'b0;
        wait_drain(20);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL cont_busy_after: got %b want 0", bus.busy); end
    endtask

    task automatic test_stop();
        y_pat = 16'h00AA;
        bus.ch_mask = 16'h00FF; bus.dwell = 8'd4; bus.start = 1'b1;
        plan_frame(16'h00FF, 8'd4);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        bus.stop = 1'b1;
        exp_q.delete();
        @(negedge clk);
        bus.stop = 1'b0;
        n_cmp++; if (bus.sel !== 4'd0) begin n_bad++; $display("FAIL stop_sel: got %0d want 0", bus.sel); end
        n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL stop_mux_en: got %b want 0", bus.mux_en); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_busy: got %b want 0", bus.busy); end
        n_cmp++;
        if (bus.sample !== last_exp_sample) begin
            n_bad++; $display("FAIL stop_sample_kept: got %h want %h", bus.sample, last_exp_sample);
        end
        repeat (3) @(negedge clk);
        bus.start = 1'b1; bus.stop = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.stop = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL stop_start_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL stop_start_mux_en: got %b want 0", bus.mux_en); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignored_starts();
        bus.ch_mask = 16'h0000; bus.dwell = 8'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL zero_mask_busy: got %b want 0", bus.busy); end
            n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL zero_mask_en: got %b want 0", bus.mux_en); end
            @(negedge clk);
        end
        y_pat = 16'h0010;
        bus.ch_mask = 16'h0030; bus.start = 1'b1;
        plan_frame(16'h0030, 8'd3);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.ch_mask = 16'hFFFF; bus.dwell = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drain(20);
    endtask

    task automatic test_async_reset();
        y_pat = 16'h00FF;
        bus.ch_mask = 16'h00FF; bus.dwell = 8'd2; bus.start = 1'b1;
        plan_frame(16'h00FF, 8'd2);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        n_cmp++; if (bus.sel !== 4'd0) begin n_bad++; $display("FAIL arst_sel: got %0d want 0", bus.sel); end
        n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL arst_mux_en: got %b want 0", bus.mux_en); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.frame_valid !== 1'b0) begin n_bad++; $display("FAIL arst_fv: got %b want 0", bus.frame_valid); end
        n_cmp++; if (bus.sample !== 16'h0) begin n_bad++; $display("FAIL arst_sample: got %h want 0", bus.sample); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.mux_en !== 1'b0) begin n_bad++; $display("FAIL arst_idle_en: got %b want 0", bus.mux_en); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        last_exp_sample = '0;
        y_pat = '0;
        rst_n = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
        bus.ch_mask = '0; bus.dwell = '0;
        fork
            monitor_loop();
        join_none
        test_reset();
        test_basic_frame();
        test_dwell_zero_full();
        test_cont_mask_update();
        test_stop();
        test_ignored_starts();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/tdm_scan_ctrl.md
Name: tdm_scan_ctrl

Overview:
- Upstream sequencer for the team's N:1 multiplexer blocks (MUX_16_to_1 class).
- Drives the mux select and enable, and steps through a masked set of input channels with a programmable dwell per channel.
- Samples the mux output bit at the end of each dwell and assembles a per-channel snapshot word.
- Publishes the snapshot once per frame with a one-cycle valid strobe. Frames run one-shot or continuously.

Parameters:
- N_CH, 16, number of mux data inputs (power of two, 2..64).
- SEL_W, 4, select width; must equal log2(N_CH).
- DWELL_W, 8, width of the dwell-count input.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin frame (sampled only in IDLE).
- stop  input  1  abort immediately.
- cont  input  1  continuous mode; restart after each frame.
- ch_mask  input  N_CH  1 = channel included in scan.
- dwell  input  DWELL_W  cycles per channel; 0 is treated as 1.
- mux_y  input  1  output of the downstream mux.
- sel  output  SEL_W  mux select.
- mux_en  output  1  mux enable.
- sample  output  N_CH  last completed frame snapshot.
- frame_valid  output  1  one-cycle strobe; sample updated.
- busy  output  1  high in DWELL and DONE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, sel=0, mux_en=0, sample=0, frame_valid=0, busy=0, internal shadow and counters cleared. Reset has immediate effect mid-frame.
- States: IDLE, DWELL, DONE.
- IDLE:
  - sel=0, mux_en=0.
  - On start=1, stop=0 and ch_mask!=0: latch mask_r=ch_mask and D=max(dwell,1), clear shadow, set sel to the lowest set bit of mask_r, dwell counter=0, go DWELL.
  - start with ch_mask==0 is ignored and the block stays IDLE.
- DWELL:
  - mux_en=1; sel holds the current channel.
  - The counter increments each cycle.
  - On the edge ending the D-th cycle on a channel: shadow[sel] <= mux_y.
    - If a higher set bit exists in mask_r, sel <= that channel and the counter resets. No gap cycle; masked channels cost zero cycles.
    - Otherwise go DONE.
- DONE (exactly 1 cycle):
  - mux_en=0, frame_valid=1.
  - sample holds the new snapshot during this cycle: it is loaded on the edge entering DONE.
  - Masked channels read 0 in sample.
  - Next state:
    - If cont=1 and ch_mask!=0: relatch mask and dwell, go DWELL at the new first channel.
    - Otherwise go IDLE.
- Frame timing: start is sampled at edge e0. The first DWELL cycle follows e0. Frame length is K*D DWELL cycles plus 1 DONE cycle, where K=popcount(mask_r).
- stop:
  - stop=1 in any state forces IDLE on the next edge: mux_en=0 and sel=0.
  - No frame_valid; sample is unchanged; shadow is discarded.
  - stop has priority over start and over a DONE-to-DWELL restart in the same cycle.
- start while busy is ignored.
- Changes to ch_mask or dwell mid-frame have no effect until the next latch point (IDLE start or DONE restart).
- frame_valid is never high for more than 1 consecutive cycle.
- mux_y is treated as synchronous to clk. The downstream mux is combinational, so the value sampled reflects the sel held for that cycle.
- Width rules:
  - The dwell counter is DWELL_W bits, and the compare is against D-1.
  - Maximum dwell is 2^DWELL_W-1 with no wrap.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, DWELL=2'd1, DONE=2'd2);
  - default N_CH, SEL_W, DWELL_W constants.
- One sub-module: tdm_next_ch, a combinational finder.
  - Inputs: mask, cur, and a mode flag (first vs. next-above).
  - Outputs: idx[SEL_W-1:0] and found.
  - Used for both the first-channel and next-channel searches.

Test Plan:
- Basic frame: ch_mask=16'h0005, dwell=2, cont=0, mux_y=(sel==2), start at e0 -> sel=0 for cycles 1-2, sel=2 for cycles 3-4, mux_en=1 for cycles 1-4, frame_valid=1 in cycle 5 only, sample=16'h0004, then IDLE and busy=0.
- Dwell zero, full mask: ch_mask=16'hFFFF, dwell=0, mux_y=1 -> sel steps 0..15, one cycle each; frame_valid in cycle 17; sample=16'hFFFF.
- Continuous with mask update: cont=1, ch_mask=16'h0003, dwell=1; change ch_mask to 16'h8000 mid-frame 1 -> frame 1 scans channels 0 and 1. DWELL resumes in the cycle after DONE with sel=15. Frame 2 length is 2 cycles.
- Stop mid-frame: ch_mask=16'h00FF, dwell=4, assert stop in cycle 6 -> IDLE at the next edge, mux_en=0, sel=0, no frame_valid, sample keeps its previous value. stop asserted together with start in IDLE -> no activity.
- Ignored starts: start with ch_mask=0 -> busy stays 0 and mux_en stays 0. A second start pulse during DWELL -> frame length unchanged and only one frame_valid.
- Async reset mid-frame: drop rst_n in cycle 3 between edges -> all outputs go to 0 immediately. After release, the block idles until start.
